aib_tx_bert_ctrl: RTL and testbench

- Control front-end that sits directly upstream of the TX BERT datapath in the adapter TX channel.
- Decodes already-synchronized register writes into the datapath's control inputs: start/reset pulses, per-generator pattern selects, per-lane generator selects, and one-hot seed-load strobes with the matching 32-bit seed word.
- Protects live generators from reconfiguration and returns a toggle acknowledge to the writer.

---
 rtl/aib_bert_pkg.sv | 27 ++
 rtl/aib_bert_tgl_det.sv | 22 ++
 rtl/aib_tx_bert_ctrl.sv | 149 ++++++++++++++
 tb/tb_aib_tx_bert_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aib_bert_pkg.sv
// Shared definitions for the TX BERT control path: register map, FIFO modes,
// generator encodings and the seed pointer layout.
package aib_bert_pkg;

    localparam logic [2:0] ADDR_CMD       = 3'd0;
    localparam logic [2:0] ADDR_PTRN      = 3'd1;
    localparam logic [2:0] ADDR_SEED_PTR  = 3'd2;
    localparam logic [2:0] ADDR_SEED_DATA = 3'd3;
    localparam logic [2:0] ADDR_LANE_LO   = 3'd4;
    localparam logic [2:0] ADDR_LANE_MID  = 3'd5;
    localparam logic [2:0] ADDR_LANE_HI   = 3'd6;

    localparam logic [1:0] FIFO_1X = 2'd0;
    localparam logic [1:0] FIFO_2X = 2'd1;
    localparam logic [1:0] FIFO_4X = 2'd2;

    localparam logic [1:0] GEN0 = 2'd0;
    localparam logic [1:0] GEN1 = 2'd1;
    localparam logic [1:0] GEN2 = 2'd2;
    localparam logic [1:0] GEN3 = 2'd3;

    typedef struct packed {
        logic [1:0] gen;
        logic [3:0] word;
    } seed_ptr_t;

endpackage

// File: rtl/aib_bert_tgl_det.sv
// Toggle edge detector: flags a request whenever the synchronized toggle
// differs from its value in the previous cycle.
module aib_bert_tgl_det (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic tgl_i,
    output logic req_vld_o
);

    logic tgl_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tgl_q <= 1'b0;
        end else begin
            tgl_q <= tgl_i;
        end
    end

    assign req_vld_o = tgl_i ^ tgl_q;

endmodule

// File: rtl/aib_tx_bert_ctrl.sv
// TX BERT control front-end: decodes synchronized register writes into
// datapath control, guards running generators and returns a toggle ack.
module aib_tx_bert_ctrl
    import aib_bert_pkg::*;
#(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NGEN   = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              wr_tgl_sync_i,
    input  logic [ADDR_W-1:0] wr_addr_sync_i,
    input  logic [31:0]       wr_data_sync_i,
    input  logic              err_clr_i,
    input  logic [NGEN-1:0]   tx_bertgen_en_i,
    input  logic [NGEN-1:0]   tx_seed_good_i,
    output logic              wr_ack_tgl_o,
    output logic [NGEN-1:0]   tx_start_pulse_o,
    output logic [NGEN-1:0]   tx_rst_pulse_o,
    output logic [2:0]        gen0_ptrn_sel_ff_o,
    output logic [2:0]        gen1_ptrn_sel_ff_o,
    output logic [2:0]        gen2_ptrn_sel_ff_o,
    output logic [2:0]        gen3_ptrn_sel_ff_o,
    output logic [79:0]       lane_gen_sel_ff_o,
    output logic [15:0]       seed_ld_0_o,
    output logic [15:0]       seed_ld_1_o,
    output logic [15:0]       seed_ld_2_o,
    output logic [15:0]       seed_ld_3_o,
    output logic [31:0]       txwdata_sync_ff_o,
    output logic [5:0]        seed_ptr_ff_o,
    output logic              err_flag_o
);

    logic                      req_vld;
    logic                      ack_q, ack_d;
    logic [NGEN-1:0]           start_q, start_d;
    logic [NGEN-1:0]           rst_q, rst_d;
    logic [NGEN-1:0][15:0]     sld_q, sld_d;
    logic [31:0]               txw_q, txw_d;
    seed_ptr_t                 ptr_q, ptr_d;
    logic [NGEN-1:0][2:0]      ptrn_q, ptrn_d;
    logic [79:0]               lane_q, lane_d;
    logic                      err_q, err_d, err_set;
    logic [NGEN-1:0]           start_req, rst_req, start_ok, start_bad;

    aib_bert_tgl_det u_tgl_det (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .tgl_i     (wr_tgl_sync_i),
        .req_vld_o (req_vld)
    );

    // Reset beats start on the same generator; a start without a good seed is dropped.
    assign start_req = wr_data_sync_i[NGEN-1:0];
    assign rst_req   = wr_data_sync_i[2*NGEN-1:NGEN];
    assign start_ok  = start_req & ~rst_req & tx_seed_good_i;
    assign start_bad = start_req & ~rst_req & ~tx_seed_good_i;

    always_comb begin
        ack_d   = ack_q;
        start_d = '0;
        rst_d   = '0;
        sld_d   = '0;
        txw_d   = txw_q;
        ptr_d   = ptr_q;
        ptrn_d  = ptrn_q;
        lane_d  = lane_q;
        err_set = 1'b0;
        if (req_vld) begin
            ack_d = ~ack_q;
            case (wr_addr_sync_i)
                ADDR_CMD: begin
                    rst_d   = rst_req;
                    start_d = start_ok;
                    err_set = |start_bad;
                end
                ADDR_PTRN: begin
                    for (int g = 0; g < NGEN; g++) begin
                        if (tx_bertgen_en_i[g]) begin
                            err_set = 1'b1;
                        end else begin
                            ptrn_d[g] = wr_data_sync_i[4*g +: 3];
                        end
                    end
                end
                ADDR_SEED_PTR: begin
                    ptr_d.gen  = wr_data_sync_i[1:0];
                    ptr_d.word = wr_data_sync_i[7:4];
                end
                ADDR_SEED_DATA: begin
                    txw_d = wr_data_sync_i;
                    if (tx_bertgen_en_i[ptr_q.gen]) begin
                        err_set = 1'b1;
                    end else begin
                        sld_d[ptr_q.gen][ptr_q.word] = 1'b1;
                        ptr_d.word = ptr_q.word + 4'd1;
                    end
                end
                ADDR_LANE_LO:  lane_d[31:0]  = wr_data_sync_i;
                ADDR_LANE_MID: lane_d[63:32] = wr_data_sync_i;
                ADDR_LANE_HI:  lane_d[79:64] = wr_data_sync_i[15:0];
                default:       err_set = 1'b1;
            endcase
        end
        // A new error outranks a simultaneous clear.
        err_d = err_set | (err_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q   <= 1'b0;
            start_q <= '0;
            rst_q   <= '0;
            sld_q   <= '0;
            txw_q   <= '0;
            ptr_q   <= '0;
            ptrn_q  <= '0;
            lane_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            start_q <= start_d;
            rst_q   <= rst_d;
            sld_q   <= sld_d;
            txw_q   <= txw_d;
            ptr_q   <= ptr_d;
            ptrn_q  <= ptrn_d;
            lane_q  <= lane_d;
            err_q   <= err_d;
        end
    end

    assign wr_ack_tgl_o       = ack_q;
    assign tx_start_pulse_o   = start_q;
    assign tx_rst_pulse_o     = rst_q;
    assign gen0_ptrn_sel_ff_o = ptrn_q[0];
    assign gen1_ptrn_sel_ff_o = ptrn_q[1];
    assign gen2_ptrn_sel_ff_o = ptrn_q[2];
    assign gen3_ptrn_sel_ff_o = ptrn_q[3];
    assign lane_gen_sel_ff_o  = lane_q;
    assign seed_ld_0_o        = sld_q[0];
    assign seed_ld_1_o        = sld_q[1];
    assign seed_ld_2_o        = sld_q[2];
    assign seed_ld_3_o        = sld_q[3];
    assign txwdata_sync_ff_o  = txw_q;
    assign seed_ptr_ff_o      = ptr_q;
    assign err_flag_o         = err_q;

endmodule

// File: tb/tb_aib_tx_bert_ctrl.sv
// Scoreboard bench for aib_tx_bert_ctrl: a register-level model pushes the
// expected post-request state, compared one edge after each request.
module tb_aib_tx_bert_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tgl = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] data = '0;
    logic        err_clr = 1'b0;
    logic [3:0]  en = '0;
    logic [3:0]  good = 4'hF;

    logic        ack;
    logic [3:0]  start_p, rst_p;
    logic [2:0]  p0, p1, p2, p3;
    logic [79:0] lane;
    logic [15:0] sld0, sld1, sld2, sld3;
    logic [31:0] txw;
    logic [5:0]  ptr;
    logic        err;

    aib_tx_bert_ctrl u_dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .wr_tgl_sync_i      (tgl),
        .wr_addr_sync_i     (addr),
        .wr_data_sync_i     (data),
        .err_clr_i          (err_clr),
        .tx_bertgen_en_i    (en),
        .tx_seed_good_i     (good),
        .wr_ack_tgl_o       (ack),
        .tx_start_pulse_o   (start_p),
        .tx_rst_pulse_o     (rst_p),
        .gen0_ptrn_sel_ff_o (p0),
        .gen1_ptrn_sel_ff_o (p1),
        .gen2_ptrn_sel_ff_o (p2),
        .gen3_ptrn_sel_ff_o (p3),
        .lane_gen_sel_ff_o  (lane),
        .seed_ld_0_o        (sld0),
        .seed_ld_1_o        (sld1),
        .seed_ld_2_o        (sld2),
        .seed_ld_3_o        (sld3),
        .txwdata_sync_ff_o  (txw),
        .seed_ptr_ff_o      (ptr),
        .err_flag_o         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ack;
        logic [3:0]  st;
        logic [3:0]  rs;
        logic [63:0] sld;
        logic [31:0] txw;
        logic [5:0]  ptr;
        logic        err;
        logic [79:0] lane;
        logic [11:0] ptrn;
    } exp_t;

    exp_t m = '0;
    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input exp_t e, input string ctx);
        check_eq({ctx, ".ack"},   80'(ack), 80'(e.ack));
        check_eq({ctx, ".start"}, 80'(start_p), 80'(e.st));
        check_eq({ctx, ".rst"},   80'(rst_p), 80'(e.rs));
        check_eq({ctx, ".sld"},   80'({sld3, sld2, sld1, sld0}), 80'(e.sld));
        check_eq({ctx, ".txw"},   80'(txw), 80'(e.txw));
        check_eq({ctx, ".ptr"},   80'(ptr), 80'(e.ptr));
        check_eq({ctx, ".err"},   80'(err), 80'(e.err));
        check_eq({ctx, ".lane"},  lane, e.lane);
        check_eq({ctx, ".ptrn"},  80'({p3, p2, p1, p0}), 80'(e.ptrn));
    endtask

    // Drive one register write and push the state the DUT must show one edge later.
    task automatic send(input logic [2:0] a, input logic [31:0] d);
        exp_t       e;
        logic [3:0] st, rs;
        logic [63:0] sl;
        int         g;
        st = '0;
        rs = '0;
        sl = '0;
        @(negedge clk);
        addr = a;
        data = d;
        tgl  = ~tgl;
        m.ack = ~m.ack;
        case (a)
            3'd0: begin
                rs = d[7:4];
                st = d[3:0] & ~d[7:4] & good;
                if ((d[3:0] & ~d[7:4] & ~good) != 4'b0) m.err = 1'b1;
            end
            3'd1: begin
                for (int k = 0; k < 4; k++) begin
                    if (en[k]) m.err = 1'b1;
                    else m.ptrn[3*k +: 3] = d[4*k +: 3];
                end
            end
            3'd2: m.ptr = {d[1:0], d[7:4]};
            3'd3: begin
                m.txw = d;
                g = int'(m.ptr[5:4]);
                if (en[g]) begin
                    m.err = 1'b1;
                end else begin
                    sl[16*g + int'(m.ptr[3:0])] = 1'b1;
                    m.ptr[3:0] = m.ptr[3:0] + 4'd1;
                end
            end
            3'd4: m.lane[31:0]  = d;
            3'd5: m.lane[63:32] = d;
            3'd6: m.lane[79:64] = d[15:0];
            default: m.err = 1'b1;
        endcase
        e     = m;
        e.st  = st;
        e.rs  = rs;
        e.sld = sl;
        q.push_back(e);
    endtask

    task automatic clr_err();
        @(negedge clk);
        err_clr = 1'b1;
        m.err   = 1'b0;
        q.push_back(m);
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) e = q.pop_front();
        else e = m;
        compare_all(e, "sb");
    end

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Seed pointer then seed data for gen0 word 3
        send(3'd2, 32'h0000_0030);
        send(3'd3, 32'hDEAD_BEEF);
        @(posedge clk); #2;
        check_eq("sd_sld0", 80'(sld0), 80'h0008);
        check_eq("sd_txw", 80'(txw), 80'hDEAD_BEEF);
        check_eq("sd_ptr", 80'(ptr), 80'h04);
        check_eq("sd_ack", 80'(ack), 80'h0);
        @(posedge clk); #2;
        check_eq("sd_sld0_one_cycle", 80'(sld0), 80'h0);

        // Word 15 wraps to 0 within gen2
        send(3'd2, 32'h0000_00F2);
        send(3'd3, 32'h1234_5678);
        @(posedge clk); #2;
        check_eq("wrap_sld2", 80'(sld2), 80'h8000);
        check_eq("wrap_ptr", 80'(ptr), 80'h20);

        // Reset wins over start; starts without a good seed are dropped
        good = 4'b0011;
        send(3'd0, 32'h0000_002F);
        @(posedge clk); #2;
        check_eq("cmd_rst", 80'(rst_p), 80'h2);
        check_eq("cmd_start", 80'(start_p), 80'h1);
        check_eq("cmd_err", 80'(err), 80'h1);
        clr_err();
        good = 4'hF;
        check_eq("cmd_err_clr", 80'(err), 80'h0);

        // Running gen2 keeps its pattern
        en = 4'b0100;
        send(3'd1, 32'h0000_7531);
        @(posedge clk); #2;
        check_eq("ptrn_g0", 80'(p0), 80'h1);
        check_eq("ptrn_g1", 80'(p1), 80'h3);
        check_eq("ptrn_g2", 80'(p2), 80'h0);
        check_eq("ptrn_g3", 80'(p3), 80'h7);
        check_eq("ptrn_err", 80'(err), 80'h1);
        clr_err();
        check_eq("ptrn_err_clr", 80'(err), 80'h0);

        // Seed data to a running generator: no strobe, no increment
        en = 4'b0001;
        send(3'd2, 32'h0000_0000);
        send(3'd3, 32'hCAFE_F00D);
        @(posedge clk); #2;
        check_eq("run_sld0", 80'(sld0), 80'h0);
        check_eq("run_ptr", 80'(ptr), 80'h0);
        check_eq("run_err", 80'(err), 80'h1);
        en = 4'b0000;
        clr_err();

        send(3'd6, 32'h0000_C000);
        @(posedge clk); #2;
        check_eq("lane_hi", lane, {2'b11, 78'b0});
        send(3'd7, 32'h0000_0000);
        @(posedge clk); #2;
        check_eq("addr7_err", 80'(err), 80'h1);
        clr_err();

        // Back-to-back requests
        send(3'd4, 32'hA5A5_5A5A);
        send(3'd5, 32'h0123_4567);
        send(3'd0, 32'h0000_0011);
        repeat (2) @(negedge clk);

        // Reset while a request is outstanding
        @(negedge clk);
        addr = 3'd0;
        data = 32'h0000_000F;
        tgl  = ~tgl;
        #2;
        rstn = 1'b0;
        q.delete();
        m = '0;
        #1;
        compare_all(m, "async_rst");
        repeat (2) @(negedge clk);
        tgl = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        send(3'd2, 32'h0000_0010);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
